// File: rtl/score_readout_if.sv
// rtl/score_readout_if.sv - read port of the 32-entry score RAM
interface score_readout_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rden;
  logic [7:0]        mem_q;

  modport master (output mem_address, output mem_rden, input mem_q);
  modport slave  (input mem_address, input mem_rden, output mem_q);
endinterface

// File: rtl/score_readout.sv
// rtl/score_readout.sv - sweeps the score RAM, finds high score/address/played count, converts to BCD
module score_readout #(
  parameter int NUM_ENTRIES = 32,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  score_readout_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [7:0]        high_score,
  output logic [ADDR_W-1:0] high_addr,
  output logic [5:0]        played_count,
  output logic [3:0]        bcd_hundreds,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, LOAD, CONVERT, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic              last_addr;
  logic              cap_valid;
  logic [ADDR_W-1:0] cap_addr;
  logic [19:0]       dd;
  logic [19:0]       dd_adj;
  logic [19:0]       dd_next;
  logic [2:0]        iter;

  assign last_addr = (mem.mem_address == ADDR_W'(NUM_ENTRIES - 1));

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last_addr) state_next = DRAIN;
      DRAIN:   state_next = LOAD;
      LOAD:    state_next = CONVERT;
      CONVERT: if (iter == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // One double-dabble step: correct each BCD nibble, then shift.
  always_comb begin
    dd_adj = dd;
    if (dd_adj[19:16] >= 4'd5) dd_adj[19:16] = dd_adj[19:16] + 4'd3;
    if (dd_adj[15:12] >= 4'd5) dd_adj[15:12] = dd_adj[15:12] + 4'd3;
    if (dd_adj[11:8]  >= 4'd5) dd_adj[11:8]  = dd_adj[11:8]  + 4'd3;
    dd_next = {dd_adj[18:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      mem.mem_address <= '0;
      mem.mem_rden    <= 1'b0;
      cap_valid       <= 1'b0;
      cap_addr        <= '0;
      high_score      <= '0;
      high_addr       <= '0;
      played_count    <= '0;
      result_valid    <= 1'b0;
      bcd_hundreds    <= '0;
      bcd_tens        <= '0;
      bcd_ones        <= '0;
      dd              <= '0;
      iter            <= '0;
    end else begin
      // mem_q arrives one cycle after its address; tag it with the delayed valid/address.
      cap_valid <= mem.mem_rden;
      cap_addr  <= mem.mem_address;
      if (cap_valid) begin
        if (mem.mem_q != 8'd0) played_count <= played_count + 6'd1;
        if (mem.mem_q > high_score) begin
          high_score <= mem.mem_q;
          high_addr  <= cap_addr;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            mem.mem_address <= '0;
            mem.mem_rden    <= 1'b1;
            high_score      <= '0;
            high_addr       <= '0;
            played_count    <= '0;
            result_valid    <= 1'b0;
            bcd_hundreds    <= '0;
            bcd_tens        <= '0;
            bcd_ones        <= '0;
          end
        end
        SCAN: begin
          if (last_addr) begin
            mem.mem_rden    <= 1'b0;
            mem.mem_address <= '0;
          end else begin
            mem.mem_address <= mem.mem_address + 1'b1;
          end
        end
        LOAD: begin
          dd   <= {12'b0, high_score};
          iter <= '0;
        end
        CONVERT: begin
          dd   <= dd_next;
          iter <= iter + 3'd1;
          if (iter == 3'd7) begin
            bcd_hundreds <= dd_next[19:16];
            bcd_tens     <= dd_next[15:12];
            bcd_ones     <= dd_next[11:8];
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_readout.sv
// tb/tb_score_readout.sv - randomized and directed checks of score_readout against a RAM model
module tb_score_readout;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        busy, done, result_valid;
  logic [7:0]  high_score;
  logic [4:0]  high_addr;
  logic [5:0]  played_count;
  logic [3:0]  bcd_hundreds, bcd_tens, bcd_ones;
  logic [7:0]  ram [32];
  int          n_assert = 0;
  int          n_fail   = 0;

  score_readout_if #(.ADDR_W(5)) bus ();

  score_readout #(.NUM_ENTRIES(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .start        (start),
    .mem          (bus),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .high_score   (high_score),
    .high_addr    (high_addr),
    .played_count (played_count),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_rden) bus.mem_q <= ram[bus.mem_address];

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: max over the RAM, lowest index holding it, count of non-zero entries.
  task automatic model(output int hs, output int ha, output int pc);
    hs = 0;
    pc = 0;
    foreach (ram[i]) begin
      if (int'(ram[i]) > hs) hs = int'(ram[i]);
      if (ram[i] != 8'd0) pc++;
    end
    ha = -1;
    foreach (ram[i]) if (ha < 0 && int'(ram[i]) == hs) ha = i;
  endtask

  task automatic check_results(input string tag);
    int hs, ha, pc;
    model(hs, ha, pc);
    check({tag, ".high_score"}, high_score, hs);
    check({tag, ".high_addr"}, high_addr, ha);
    check({tag, ".played"}, played_count, pc);
    check({tag, ".bcd_h"}, bcd_hundreds, hs / 100);
    check({tag, ".bcd_t"}, bcd_tens, (hs / 10) % 10);
    check({tag, ".bcd_o"}, bcd_ones, hs % 10);
    check({tag, ".valid"}, result_valid, 1);
  endtask

  task automatic run(input string tag, input bit repulse, input bit rst_mid);
    int done_cycle = -1;
    int done_cnt   = 0;
    int rden_cnt   = 0;
    int addr_bad   = 0;
    int busy_bad   = 0;
    int busy_last  = rst_mid ? 10 : 42;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cycle = c;
      end
      if (bus.mem_rden) begin
        rden_cnt++;
        if (int'(bus.mem_address) != c) addr_bad++;
      end
      if (busy !== (c <= busy_last)) busy_bad++;
      if (c == 0) begin
        check({tag, ".cleared_valid"}, result_valid, 0);
        check({tag, ".cleared_hs"}, high_score, 0);
      end
      if (rst_mid && c == 11) begin
        check({tag, ".rst_hs"}, high_score, 0);
        check({tag, ".rst_played"}, played_count, 0);
        check({tag, ".rst_addr"}, bus.mem_address, 0);
        check({tag, ".rst_rden"}, bus.mem_rden, 0);
        check({tag, ".rst_valid"}, result_valid, 0);
      end
      Reset = rst_mid && (c == 10);
      start = repulse && (c == 5 || c == 42);
    end
    check({tag, ".done_count"}, done_cnt, rst_mid ? 0 : 1);
    check({tag, ".rden_cycles"}, rden_cnt, rst_mid ? 11 : 32);
    check({tag, ".addr_seq"}, addr_bad, 0);
    check({tag, ".busy_window"}, busy_bad, 0);
    if (!rst_mid) begin
      check({tag, ".done_cycle"}, done_cycle, 42);
      check_results(tag);
    end
  endtask

  initial begin
    foreach (ram[i]) ram[i] = 8'd0;
    Reset = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.rden", bus.mem_rden, 0);
    check("reset.addr", bus.mem_address, 0);
    check("reset.valid", result_valid, 0);
    check("reset.outputs", {high_score, 3'b0, high_addr, 2'b0, played_count,
                            bcd_hundreds, bcd_tens, bcd_ones}, 0);
    start = 1'b0;
    Reset = 1'b0;

    run("empty", 1'b0, 1'b0);

    ram[7] = 8'd255;
    run("single255", 1'b0, 1'b0);

    foreach (ram[i]) ram[i] = 8'd0;
    ram[3] = 8'd42; ram[20] = 8'd42; ram[31] = 8'd9; ram[0] = 8'd17;
    run("ties", 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("hold.high_score", high_score, 42);
    check("hold.high_addr", high_addr, 3);
    check("hold.valid", result_valid, 1);

    foreach (ram[i]) ram[i] = 8'($urandom_range(0, 255));
    run("repulse", 1'b1, 1'b0);

    foreach (ram[i]) ram[i] = 8'($urandom_range(1, 255));
    run("rst_mid", 1'b0, 1'b1);
    run("after_rst", 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      foreach (ram[i]) ram[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/score_readout.md
# score_readout

End-of-game score reader for the score RAM, the read-side counterpart to the game datapath that writes one 8-bit score per round into the 32-entry single-port RAM. On a `start` pulse from the game controller, the block:

- sweeps the RAM,
- finds the high score, its address and the number of rounds played,
- converts the high score to three BCD digits for the 7-segment display driver.

It never writes the RAM.

## Interface

Parameters:
- NUM_ENTRIES, 32, number of RAM entries scanned from address 0; legal 1..32
- ADDR_W, 5, RAM address width

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  begin a readout; sampled only in IDLE
- mem_q  in  8  RAM read data
  - 1-cycle read latency: mem_q in cycle t+1 = RAM[mem_address in cycle t]
- mem_address  out  ADDR_W  RAM read address
- mem_rden  out  1  read enable; high while addresses are being issued
- busy  out  1  high from the cycle after start is accepted until done drops
- done  out  1  one-cycle pulse; results valid from this cycle
- result_valid  out  1  set with done; cleared by Reset or by the next accepted start
- high_score  out  8  maximum entry found
- high_addr  out  ADDR_W  lowest address holding high_score
- played_count  out  6  number of non-zero entries, 0..32
- bcd_hundreds, bcd_tens, bcd_ones  out  4 each  BCD of high_score

## Operation

- Reset values: all outputs 0; state = IDLE.
- State IDLE
  - On start=1 (registered at edge E0):
    - mem_address←0, mem_rden←1
    - clear high_score, high_addr, played_count, result_valid and the BCD digits
    - →SCAN
- State SCAN
  - mem_address increments by 1 each edge up to NUM_ENTRIES−1.
  - After the last address is issued: mem_rden←0, mem_address←0, →DRAIN.
- Capture pipe
  - A 1-bit valid and the issued address are delayed one cycle to tag mem_q.
  - Each tagged mem_q is processed as follows:
    - if non-zero, played_count+1
    - if strictly greater than high_score, update high_score and high_addr
  - Ties keep the lower address.
- State DRAIN
  - Captures the final entry, then →LOAD.
- State LOAD
  - Loads the 20-bit double-dabble register {12'b0, high_score}, then →CONVERT.
- State CONVERT
  - Exactly 8 iterations.
  - Each iteration, in this order:
    - add 3 to any BCD nibble ≥5
    - shift left 1
  - After the 8th iteration: register the three digits, →DONE.
- State DONE
  - done=1 and result_valid←1 for one cycle, then →IDLE.
- Arithmetic rules
  - Scores are unsigned 8-bit; 255 converts to 2/5/5.
  - played_count never exceeds NUM_ENTRIES.
- Boundary conditions
  - start while busy: ignored and not queued.
  - start in the DONE cycle: ignored.
  - start held high across several IDLE cycles: only one readout per entry into IDLE.
  - After DONE, a still-high start does restart a readout.
  - Reset mid-operation (any state): next cycle state=IDLE and all outputs at reset values; done is not pulsed.
  - NUM_ENTRIES=1: SCAN lasts one cycle; the same pipeline and latency formula apply.
  - Results hold unchanged in IDLE until the next accepted start or Reset.

## Timing

- The sweep issues one address per cycle.
  - Address k is driven in the cycle after edge E_k (k=0..NUM_ENTRIES−1).
  - Its data is captured at E_{k+2}.
- The last capture is at E_{NUM_ENTRIES+1}.
- LOAD happens at E_{NUM_ENTRIES+2}.
- The 8 CONVERT shifts happen at E_{NUM_ENTRIES+3}..E_{NUM_ENTRIES+10}.
- done is high in the single cycle after E_{NUM_ENTRIES+10}; this is 42 cycles after the start edge for NUM_ENTRIES=32.
- busy rises after E0 and falls with the IDLE return at E_{NUM_ENTRIES+11}.
- mem_rden is high exactly NUM_ENTRIES consecutive cycles.

## Test plan

- **Reset values:** assert Reset 2 cycles with start=1 → all outputs 0, mem_rden=0, no done.
- **Empty RAM:** RAM all zero, pulse start → done at cycle 42; high_score=0, high_addr=0, played_count=0, BCD 0/0/0, result_valid=1.
- **Single 255:** RAM[7]=255, others 0 → high_score=255, high_addr=7, played_count=1, BCD 2/5/5.
- **Ties and count:**
  - Stimulus: RAM[3]=42, RAM[20]=42, RAM[31]=9, RAM[0]=17.
  - Required: high_score=42, high_addr=3, played_count=4, BCD 0/4/2.
  - mem_address sequence 0..31 on consecutive cycles with mem_rden=1 exactly 32 cycles.
- **Start while busy:** start re-pulsed at cycles 5 and 42 (DONE cycle) → exactly one done pulse; no restart.
- **Reset mid-scan:**
  - Stimulus: Reset at cycle 10 of the sweep, then a fresh start.
  - Required: outputs cleared and no done from the first run; second run completes with correct results 42 cycles after its start.
